// File: rtl/multi_tick_sum.sv
// N-channel event accumulator: per-channel inc/clr/load counters with sticky overflow,
// a combinational full-width sum of all channels, and a snapshot register for that sum.
module multi_tick_sum #(
  parameter int N        = 2,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int INIT     = 0,
  parameter int CW       = (N > 1) ? $clog2(N) : 1,
  parameter int SW       = WIDTH + ((N > 1) ? $clog2(N) : 1)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [N-1:0]       inc,
  input  logic [N-1:0]       clr,
  input  logic               load_en,
  input  logic [CW-1:0]      load_ch,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               snap,
  output logic [N*WIDTH-1:0] count_flat,
  output logic [SW-1:0]      sum,
  output logic [SW-1:0]      snap_sum,
  output logic               snap_valid,
  output logic [N-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic [WIDTH-1:0] w_cnt [N];
  logic [SW-1:0]    w_sum;
  logic [SW-1:0]    r_snap_sum;
  logic             r_snap_valid;

  for (genvar g = 0; g < N; g++) begin : g_ch
    localparam logic [CW-1:0] CH_SEL = CW'(g);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             w_load_hit;

    // A select value of N or above matches no channel, so such a load is dropped.
    assign w_load_hit = load_en && (load_ch == CH_SEL);

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= INIT_VAL;
        r_ovf <= 1'b0;
      end else if (clr[g]) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_load_hit) begin
        r_cnt <= load_val;
        r_ovf <= 1'b0;
      end else if (inc[g]) begin
        if (r_cnt == MAX_VAL) begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end

    assign w_cnt[g]                      = r_cnt;
    assign count_flat[g*WIDTH +: WIDTH] = r_cnt;
    assign ovf[g]                        = r_ovf;
  end

  // SW leaves room for N maximal channels, so the zero-extended sum cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + SW'(w_cnt[i]);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_sum   <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= snap;
      if (snap) r_snap_sum <= w_sum;
    end
  end

  assign sum        = w_sum;
  assign snap_sum   = r_snap_sum;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_multi_tick_sum.sv
// Directed bench for multi_tick_sum: wrap, saturate, 4-channel and INIT=5 instances
// share one clock and reset; every expected value is hand-computed.
module tb_multi_tick_sum;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // a: N=2 wrap, b: N=2 saturate, c: N=4, d: N=3 INIT=5
  logic [1:0] a_inc, a_clr; logic a_le; logic [0:0] a_lch; logic [7:0] a_lv; logic a_snap;
  logic [15:0] a_cnt; logic [8:0] a_sum, a_ssum; logic a_sv; logic [1:0] a_ovf;
  logic [1:0] b_inc, b_clr; logic b_le; logic [0:0] b_lch; logic [7:0] b_lv; logic b_snap;
  logic [15:0] b_cnt; logic [8:0] b_sum, b_ssum; logic b_sv; logic [1:0] b_ovf;
  logic [3:0] c_inc, c_clr; logic c_le; logic [1:0] c_lch; logic [7:0] c_lv; logic c_snap;
  logic [31:0] c_cnt; logic [9:0] c_sum, c_ssum; logic c_sv; logic [3:0] c_ovf;
  logic [2:0] d_inc, d_clr; logic d_le; logic [1:0] d_lch; logic [7:0] d_lv; logic d_snap;
  logic [23:0] d_cnt; logic [9:0] d_sum, d_ssum; logic d_sv; logic [2:0] d_ovf;

  multi_tick_sum #(.N(2), .WIDTH(8), .SATURATE(0), .INIT(0)) u_a (
    .clock(clock), .rst_n(rst_n), .inc(a_inc), .clr(a_clr), .load_en(a_le), .load_ch(a_lch),
    .load_val(a_lv), .snap(a_snap), .count_flat(a_cnt), .sum(a_sum), .snap_sum(a_ssum),
    .snap_valid(a_sv), .ovf(a_ovf));
  multi_tick_sum #(.N(2), .WIDTH(8), .SATURATE(1), .INIT(0)) u_b (
    .clock(clock), .rst_n(rst_n), .inc(b_inc), .clr(b_clr), .load_en(b_le), .load_ch(b_lch),
    .load_val(b_lv), .snap(b_snap), .count_flat(b_cnt), .sum(b_sum), .snap_sum(b_ssum),
    .snap_valid(b_sv), .ovf(b_ovf));
  multi_tick_sum #(.N(4), .WIDTH(8), .SATURATE(0), .INIT(0)) u_c (
    .clock(clock), .rst_n(rst_n), .inc(c_inc), .clr(c_clr), .load_en(c_le), .load_ch(c_lch),
    .load_val(c_lv), .snap(c_snap), .count_flat(c_cnt), .sum(c_sum), .snap_sum(c_ssum),
    .snap_valid(c_sv), .ovf(c_ovf));
  multi_tick_sum #(.N(3), .WIDTH(8), .SATURATE(0), .INIT(5)) u_d (
    .clock(clock), .rst_n(rst_n), .inc(d_inc), .clr(d_clr), .load_en(d_le), .load_ch(d_lch),
    .load_val(d_lv), .snap(d_snap), .count_flat(d_cnt), .sum(d_sum), .snap_sum(d_ssum),
    .snap_valid(d_sv), .ovf(d_ovf));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (a_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_a_cnt got %h exp 0000", a_cnt); end
    n_vec++; if (a_sum !== 9'd0) begin n_err++; $display("FAIL reset_a_sum got %0d exp 0", a_sum); end
    n_vec++; if (a_ovf !== 2'b00 || a_sv !== 1'b0 || a_ssum !== 9'd0) begin n_err++;
      $display("FAIL reset_a_flags got ovf=%b sv=%b ssum=%0d exp 00 0 0", a_ovf, a_sv, a_ssum); end
    n_vec++; if (d_cnt !== 24'h050505) begin n_err++; $display("FAIL reset_d_init got %h exp 050505", d_cnt); end
    n_vec++; if (d_sum !== 10'd15) begin n_err++; $display("FAIL reset_d_sum got %0d exp 15", d_sum); end
  endtask

  task automatic test_inc_both();
    a_inc = 2'b11;
    repeat (3) step();
    a_inc = 2'b00;
    n_vec++; if (a_cnt !== 16'h0303) begin n_err++; $display("FAIL inc_cnt got %h exp 0303", a_cnt); end
    n_vec++; if (a_sum !== 9'd6) begin n_err++; $display("FAIL inc_sum got %0d exp 6", a_sum); end
    n_vec++; if (a_ovf !== 2'b00) begin n_err++; $display("FAIL inc_ovf got %b exp 00", a_ovf); end
  endtask

  task automatic test_wrap();
    a_le = 1'b1; a_lch = 1'b0; a_lv = 8'd255;
    step();
    a_le = 1'b0;
    n_vec++; if (a_sum !== 9'd258) begin n_err++; $display("FAIL wrap_load_sum got %0d exp 258", a_sum); end
    a_inc = 2'b01;
    step();
    n_vec++; if (a_cnt !== 16'h0300 || a_ovf !== 2'b01) begin n_err++;
      $display("FAIL wrap_roll got cnt=%h ovf=%b exp 0300 01", a_cnt, a_ovf); end
    step();
    n_vec++; if (a_cnt !== 16'h0301 || a_ovf !== 2'b01) begin n_err++;
      $display("FAIL wrap_sticky got cnt=%h ovf=%b exp 0301 01", a_cnt, a_ovf); end
    a_inc = 2'b00; a_clr = 2'b01;
    step();
    a_clr = 2'b00;
    n_vec++; if (a_cnt !== 16'h0300 || a_ovf !== 2'b00) begin n_err++;
      $display("FAIL wrap_clr got cnt=%h ovf=%b exp 0300 00", a_cnt, a_ovf); end
  endtask

  task automatic test_saturate();
    b_le = 1'b1; b_lch = 1'b1; b_lv = 8'd255;
    step();
    b_le = 1'b0; b_inc = 2'b10;
    repeat (2) step();
    b_inc = 2'b00;
    n_vec++; if (b_cnt !== 16'hFF00 || b_ovf !== 2'b10) begin n_err++;
      $display("FAIL sat_hold got cnt=%h ovf=%b exp FF00 10", b_cnt, b_ovf); end
    n_vec++; if (b_sum !== 9'd255) begin n_err++; $display("FAIL sat_sum got %0d exp 255", b_sum); end
    b_le = 1'b1; b_lch = 1'b1; b_lv = 8'd10;
    step();
    b_le = 1'b0;
    n_vec++; if (b_cnt !== 16'h0A00 || b_ovf !== 2'b00) begin n_err++;
      $display("FAIL sat_reload got cnt=%h ovf=%b exp 0A00 00", b_cnt, b_ovf); end
  endtask

  task automatic test_priority();
    a_clr = 2'b01; a_le = 1'b1; a_lch = 1'b0; a_lv = 8'd7; a_inc = 2'b01;
    step();
    a_clr = 2'b00;
    n_vec++; if (a_cnt !== 16'h0300) begin n_err++; $display("FAIL prio_clr got %h exp 0300", a_cnt); end
    step();
    a_le = 1'b0; a_inc = 2'b00;
    n_vec++; if (a_cnt !== 16'h0307) begin n_err++; $display("FAIL prio_load got %h exp 0307", a_cnt); end
    d_le = 1'b1; d_lch = 2'd3; d_lv = 8'd99;
    step();
    d_le = 1'b0;
    n_vec++; if (d_cnt !== 24'h050505) begin n_err++; $display("FAIL load_oob got %h exp 050505", d_cnt); end
  endtask

  task automatic test_snap();
    a_le = 1'b1; a_lch = 1'b0; a_lv = 8'd4;
    step();
    a_lch = 1'b1; a_lv = 8'd5;
    step();
    a_le = 1'b0; a_snap = 1'b1; a_inc = 2'b11;
    step();
    a_snap = 1'b0; a_inc = 2'b00;
    n_vec++; if (a_ssum !== 9'd9 || a_sv !== 1'b1) begin n_err++;
      $display("FAIL snap_one got ssum=%0d sv=%b exp 9 1", a_ssum, a_sv); end
    n_vec++; if (a_sum !== 9'd11) begin n_err++; $display("FAIL snap_sum_live got %0d exp 11", a_sum); end
    step();
    n_vec++; if (a_sv !== 1'b0 || a_ssum !== 9'd9) begin n_err++;
      $display("FAIL snap_drop got sv=%b ssum=%0d exp 0 9", a_sv, a_ssum); end
  endtask

  task automatic test_back_to_back();
    a_snap = 1'b1; a_inc = 2'b11;
    step();
    n_vec++; if (a_ssum !== 9'd11 || a_sv !== 1'b1) begin n_err++;
      $display("FAIL b2b_first got ssum=%0d sv=%b exp 11 1", a_ssum, a_sv); end
    step();
    a_snap = 1'b0; a_inc = 2'b00;
    n_vec++; if (a_ssum !== 9'd13 || a_sv !== 1'b1) begin n_err++;
      $display("FAIL b2b_second got ssum=%0d sv=%b exp 13 1", a_ssum, a_sv); end
    n_vec++; if (a_sum !== 9'd15) begin n_err++; $display("FAIL b2b_sum got %0d exp 15", a_sum); end
    step();
    n_vec++; if (a_sv !== 1'b0 || a_ssum !== 9'd13) begin n_err++;
      $display("FAIL b2b_end got sv=%b ssum=%0d exp 0 13", a_sv, a_ssum); end
  endtask

  task automatic test_n4_async_reset();
    c_le = 1'b1; c_lv = 8'd255;
    for (int ch = 0; ch < 4; ch++) begin
      c_lch = 2'(ch);
      c_snap = (ch == 3);
      step();
    end
    c_le = 1'b0; c_snap = 1'b0;
    n_vec++; if (c_sum !== 10'd1020 || c_cnt !== 32'hFFFF_FFFF) begin n_err++;
      $display("FAIL n4_full got sum=%0d cnt=%h exp 1020 FFFFFFFF", c_sum, c_cnt); end
    n_vec++; if (c_ssum !== 10'd765 || c_sv !== 1'b1) begin n_err++;
      $display("FAIL n4_snap got ssum=%0d sv=%b exp 765 1", c_ssum, c_sv); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (c_sum !== 10'd0 || c_cnt !== 32'h0 || c_ssum !== 10'd0 || c_sv !== 1'b0 || c_ovf !== 4'h0) begin
      n_err++; $display("FAIL async_rst_c got sum=%0d cnt=%h ssum=%0d sv=%b exp 0 0 0 0", c_sum, c_cnt, c_ssum, c_sv); end
    n_vec++; if (a_ssum !== 9'd0 || a_cnt !== 16'h0 || d_sum !== 10'd15) begin n_err++;
      $display("FAIL async_rst_ad got a_ssum=%0d a_cnt=%h d_sum=%0d exp 0 0 15", a_ssum, a_cnt, d_sum); end
    @(negedge clock) rst_n = 1'b1;
    step();
    n_vec++; if (c_sum !== 10'd0) begin n_err++; $display("FAIL post_rst_sum got %0d exp 0", c_sum); end
  endtask

  initial begin
    a_inc = '0; a_clr = '0; a_le = 0; a_lch = '0; a_lv = '0; a_snap = 0;
    b_inc = '0; b_clr = '0; b_le = 0; b_lch = '0; b_lv = '0; b_snap = 0;
    c_inc = '0; c_clr = '0; c_le = 0; c_lch = '0; c_lv = '0; c_snap = 0;
    d_inc = '0; d_clr = '0; d_le = 0; d_lch = '0; d_lv = '0; d_snap = 0;
    #12;
    test_reset();
    @(negedge clock) rst_n = 1'b1;
    #1;
    test_inc_both();
    test_wrap();
    test_saturate();
    test_priority();
    test_snap();
    test_back_to_back();
    test_n4_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
